// File: rtl/sram_arbiter.sv
`default_nettype none
// -----------------------------------------------------------------------------
// sram_arbiter: instruction/data arbiter for one single-ported SRAM   rev 1.0
// -----------------------------------------------------------------------------
module sram_arbiter #(
   parameter int SRAM_LAT   = 1,
   parameter int STARVE_MAX = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        ireq,
   input  logic [31:0] iaddr,
   output logic [31:0] irdata,
   output logic        iack,
   input  logic        dreq,
   input  logic        dwe,
   input  logic [31:0] daddr,
   input  logic [31:0] dwdata,
   output logic [31:0] drdata,
   output logic        dack,
   output logic        istall,
   output logic        dstall,
   output logic [31:0] sram_a,
   output logic        sram_re,
   output logic        sram_we,
   output logic [31:0] sram_wdata,
   input  logic [31:0] sram_rdata
);

   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] ACCESS = 2'd1;
   localparam logic [1:0] WAIT   = 2'd2;
   localparam logic [1:0] DONE   = 2'd3;

   localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);
   localparam logic [2:0] WAIT_INIT  = 3'(SRAM_LAT - 1);

   logic [1:0]  state_q, state_d;
   logic        owner_q, owner_d;   // 1 = data port owns the access
   logic        we_q, we_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic [31:0] rdata_q, rdata_d;
   logic [2:0]  wait_q, wait_d;
   logic [3:0]  starve_q, starve_d;
   logic        iwin;

   // Data has priority unless the instruction side has been passed over too often.
   assign iwin = ireq & (~dreq | (starve_q == STARVE_LIM));

   always_comb begin
      state_d  = state_q;
      owner_d  = owner_q;
      we_d     = we_q;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      rdata_d  = rdata_q;
      wait_d   = wait_q;
      starve_d = ireq ? starve_q : 4'd0;
      case (state_q)
         IDLE: begin
            if (ireq | dreq) begin
               state_d = ACCESS;
               owner_d = ~iwin;
               if (iwin) begin
                  we_d     = 1'b0;
                  addr_d   = iaddr;
                  wdata_d  = 32'd0;
                  starve_d = 4'd0;
               end else begin
                  we_d    = dwe;
                  addr_d  = daddr;
                  wdata_d = dwdata;
                  if (ireq && (starve_q != STARVE_LIM))
                     starve_d = starve_q + 4'd1;
               end
            end
         end
         ACCESS: begin
            state_d = we_q ? DONE : WAIT;
            wait_d  = WAIT_INIT;
         end
         WAIT: begin
            if (wait_q == 3'd0) begin
               rdata_d = sram_rdata;
               state_d = DONE;
            end else begin
               wait_d = wait_q - 3'd1;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         owner_q  <= 1'b0;
         we_q     <= 1'b0;
         addr_q   <= 32'd0;
         wdata_q  <= 32'd0;
         rdata_q  <= 32'd0;
         wait_q   <= 3'd0;
         starve_q <= 4'd0;
      end else begin
         state_q  <= state_d;
         owner_q  <= owner_d;
         we_q     <= we_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         rdata_q  <= rdata_d;
         wait_q   <= wait_d;
         starve_q <= starve_d;
      end
   end

   assign sram_re    = (state_q == ACCESS) & ~we_q;
   assign sram_we    = (state_q == ACCESS) &  we_q;
   assign sram_a     = (state_q == ACCESS) ? addr_q : 32'd0;
   assign sram_wdata = sram_we ? wdata_q : 32'd0;

   assign iack   = (state_q == DONE) & ~owner_q;
   assign dack   = (state_q == DONE) &  owner_q;
   assign irdata = (iack & ~we_q) ? rdata_q : 32'd0;
   assign drdata = (dack & ~we_q) ? rdata_q : 32'd0;
   assign istall = ireq & ~iack;
   assign dstall = dreq & ~dack;

endmodule
`default_nettype wire

// File: tb/tb_sram_arbiter.sv
`default_nettype none
// -----------------------------------------------------------------------------
// tb_sram_arbiter: randomized scoreboard bench for sram_arbiter       rev 1.0
// -----------------------------------------------------------------------------
module tb_sram_arbiter;

   localparam int LAT    = 3;
   localparam int STARVE = 2;

   logic        clk = 1'b0;
   logic        rst;
   logic        ireq, dreq, dwe;
   logic [31:0] iaddr, daddr, dwdata;
   logic [31:0] irdata, drdata, sram_a, sram_wdata, sram_rdata;
   logic        iack, dack, istall, dstall, sram_re, sram_we;

   sram_arbiter #(.SRAM_LAT(LAT), .STARVE_MAX(STARVE)) dut (
      .clk(clk), .rst(rst),
      .ireq(ireq), .iaddr(iaddr), .irdata(irdata), .iack(iack),
      .dreq(dreq), .dwe(dwe), .daddr(daddr), .dwdata(dwdata),
      .drdata(drdata), .dack(dack), .istall(istall), .dstall(dstall),
      .sram_a(sram_a), .sram_re(sram_re), .sram_we(sram_we),
      .sram_wdata(sram_wdata), .sram_rdata(sram_rdata)
   );

   always #5 clk = ~clk;

   typedef struct { int cyc; logic re; logic we; logic [31:0] a; logic [31:0] wd; } acc_t;
   typedef struct { int cyc; logic own_d; logic [31:0] data; } rsp_t;

   acc_t        acc_q[$];
   rsp_t        rsp_q[$];
   logic [31:0] sram_mem[logic [31:0]];
   logic [31:0] ref_mem[logic [31:0]];
   int          cyc = 0;
   int          n_chk = 0;
   int          n_fail = 0;

   function automatic logic [31:0] init_val(input logic [31:0] a);
      return a ^ {a[15:0], a[31:16]} ^ 32'h5A5A_C3C3;
   endfunction

   function automatic logic [31:0] rand_addr();
      logic [31:0] hi;
      hi = ($urandom_range(0, 1) == 1) ? 32'hF000_0000 : 32'd0;
      return hi | 32'($urandom_range(0, 15) << 2) | 32'($urandom_range(0, 3));
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   // SRAM behaviour: data for a read is valid only LAT cycles after the strobe cycle.
   logic        rd_pend = 1'b0;
   int          rd_due;
   logic [31:0] rd_data;
   always @(negedge clk) begin
      if (rd_pend && rd_due == cyc) begin
         sram_rdata = rd_data;
         rd_pend    = 1'b0;
      end else begin
         sram_rdata = $urandom;
      end
      if (sram_we === 1'b1) sram_mem[sram_a] = sram_wdata;
      if (sram_re === 1'b1) begin
         rd_pend = 1'b1;
         rd_due  = cyc + LAT;
         rd_data = sram_mem.exists(sram_a) ? sram_mem[sram_a] : init_val(sram_a);
      end
   end

   // Transaction-level reference: one access at a time, predicted from the arbitration rules.
   logic        busy = 1'b0;
   logic        own_d;
   int          t_done;
   int          starve = 0;
   logic        d_inflight = 1'b0;
   always @(negedge clk) begin
      logic        accepted, iwin, we;
      logic [31:0] a, wd, rv;
      accepted = 1'b0;
      if (cyc >= 1) begin
         if (busy && cyc == t_done) begin
            busy = 1'b0;
         end else if (!busy && !rst && (ireq || dreq)) begin
            accepted = 1'b1;
            iwin = ireq && (!dreq || starve == STARVE);
            if (iwin) begin
               own_d = 1'b0; we = 1'b0; a = iaddr; wd = 32'd0; starve = 0;
            end else begin
               own_d = 1'b1; we = dwe; a = daddr; wd = dwe ? dwdata : 32'd0;
               starve = ireq ? ((starve + 1 > STARVE) ? STARVE : starve + 1) : 0;
            end
            t_done = cyc + (we ? 2 : 2 + LAT);
            acc_q.push_back('{cyc + 1, !we, we, a, wd});
            if (we) begin
               ref_mem[a] = wd;
               rv = 32'd0;
            end else begin
               rv = ref_mem.exists(a) ? ref_mem[a] : init_val(a);
            end
            rsp_q.push_back('{t_done, own_d, rv});
            busy = 1'b1;
         end
         if (!accepted && !ireq) starve = 0;
         if (rst) begin
            busy = 1'b0;
            starve = 0;
            while (acc_q.size() > 0 && acc_q[$].cyc > cyc) void'(acc_q.pop_back());
            while (rsp_q.size() > 0 && rsp_q[$].cyc > cyc) void'(rsp_q.pop_back());
         end
      end
      d_inflight = busy && own_d;
   end

   // Monitor: pops expectations whenever the DUT strobes the SRAM or acknowledges.
   logic i_ack_seen = 1'b0;
   logic d_ack_seen = 1'b0;
   always @(negedge clk) begin
      acc_t e;
      rsp_t r;
      i_ack_seen = iack;
      d_ack_seen = dack;
      if (cyc >= 1) begin
         chk("re_we_exclusive", 32'(sram_re & sram_we), 32'd0);
         chk("ack_exclusive", 32'(iack & dack), 32'd0);
         chk("istall", 32'(istall), 32'(ireq & ~iack));
         chk("dstall", 32'(dstall), 32'(dreq & ~dack));
         if (sram_re || sram_we) begin
            if (acc_q.size() == 0) begin
               chk("unexpected_access", {30'd0, sram_re, sram_we}, 32'd0);
            end else begin
               e = acc_q.pop_front();
               chk("access_cycle", cyc, e.cyc);
               chk("sram_re", 32'(sram_re), 32'(e.re));
               chk("sram_we", 32'(sram_we), 32'(e.we));
               chk("sram_a", sram_a, e.a);
               chk("sram_wdata", sram_wdata, e.wd);
            end
         end else begin
            chk("sram_a_idle", sram_a, 32'd0);
            chk("sram_wdata_idle", sram_wdata, 32'd0);
         end
         while (acc_q.size() > 0 && acc_q[0].cyc < cyc) begin
            e = acc_q.pop_front();
            chk("missing_access_at", cyc, e.cyc);
         end
         if (iack || dack) begin
            if (rsp_q.size() == 0) begin
               chk("unexpected_ack", {30'd0, iack, dack}, 32'd0);
            end else begin
               r = rsp_q.pop_front();
               chk("ack_cycle", cyc, r.cyc);
               chk("ack_owner", {30'd0, iack, dack}, r.own_d ? 32'd1 : 32'd2);
               chk("irdata", irdata, r.own_d ? 32'd0 : r.data);
               chk("drdata", drdata, r.own_d ? r.data : 32'd0);
            end
         end else begin
            chk("irdata_idle", irdata, 32'd0);
            chk("drdata_idle", drdata, 32'd0);
         end
         while (rsp_q.size() > 0 && rsp_q[0].cyc < cyc) begin
            r = rsp_q.pop_front();
            chk("missing_ack_at", cyc, r.cyc);
         end
      end
   end

   // Requesters hold until ack, then either drop or immediately re-request.
   task automatic run_cycles(input int n, input int i_pct, input int d_pct,
                             input int i_again, input int d_again, input int rst_pm);
      for (int k = 0; k < n; k++) begin
         @(posedge clk); #1;
         rst = ($urandom_range(0, 999) < rst_pm);
         if (ireq && i_ack_seen) begin
            if ($urandom_range(0, 99) < i_again) iaddr = rand_addr();
            else ireq = 1'b0;
         end else if (!ireq && $urandom_range(0, 99) < i_pct) begin
            ireq = 1'b1; iaddr = rand_addr();
         end
         if (dreq && d_ack_seen) begin
            if ($urandom_range(0, 99) < d_again) begin
               dwe = $urandom_range(0, 1); daddr = rand_addr(); dwdata = $urandom;
            end else begin
               dreq = 1'b0;
            end
         end else if (!dreq && $urandom_range(0, 99) < d_pct) begin
            dreq = 1'b1; dwe = $urandom_range(0, 1); daddr = rand_addr(); dwdata = $urandom;
         end else if (dreq && d_inflight && $urandom_range(0, 2) == 0) begin
            daddr = $urandom; dwdata = $urandom;
         end
      end
   endtask

   initial begin
      rst = 1'b1; ireq = 1'b0; dreq = 1'b0; dwe = 1'b0;
      iaddr = 32'd0; daddr = 32'd0; dwdata = 32'd0; sram_rdata = 32'd0;
      sram_mem[32'h40] = 32'h1234_5678;
      ref_mem[32'h40]  = 32'h1234_5678;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      // single instruction read
      ireq = 1'b1; iaddr = 32'h40;
      run_cycles(10, 0, 0, 0, 0, 0);
      // simultaneous fetch and data write: data first
      ireq = 1'b1; iaddr = 32'h44;
      dreq = 1'b1; dwe = 1'b1; daddr = 32'h100; dwdata = 32'hAA;
      run_cycles(16, 0, 0, 0, 0, 0);
      // data held continuously against a waiting fetch
      ireq = 1'b1; iaddr = 32'h48;
      dreq = 1'b1; dwe = 1'b0; daddr = 32'h100;
      run_cycles(40, 0, 0, 0, 100, 0);
      run_cycles(20, 0, 0, 0, 0, 0);
      // reset in the middle of a read's wait phase, request left asserted
      dreq = 1'b1; dwe = 1'b0; daddr = 32'h104;
      run_cycles(2, 0, 0, 0, 0, 0);
      rst = 1'b1;
      @(posedge clk); #1 rst = 1'b0;
      run_cycles(20, 0, 0, 0, 0, 0);
      // random traffic
      run_cycles(1500, 30, 30, 50, 50, 0);
      run_cycles(1500, 70, 70, 80, 80, 5);
      run_cycles(80, 0, 0, 0, 0, 0);
      chk("pending_accesses", 32'(acc_q.size()), 32'd0);
      chk("pending_acks", 32'(rsp_q.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/sram_arbiter.md
SRAM_ARBITER -- requirements
Module: sram_arbiter

Interface
REQ-001 SHALL have parameter SRAM_LAT, default 1, SRAM read latency in cycles (legal range 1..7).
REQ-002 SHALL have parameter STARVE_MAX, default 4, maximum consecutive data grants while an instruction request waits (legal range 1..15).
REQ-003 SHALL have port clk, input, 1, single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1, reset, synchronous and active-high.
REQ-005 SHALL have port ireq, input, 1, instruction-fetch read request; held until iack.
REQ-006 SHALL have port iaddr, input, 32, fetch address; stable while ireq is high.
REQ-007 SHALL have port irdata, output, 32, fetch data; valid only while iack is high.
REQ-008 SHALL have port iack, output, 1, one-cycle completion pulse for the fetch.
REQ-009 SHALL have port dreq, input, 1, data-access request; held until dack.
REQ-010 SHALL have port dwe, input, 1, 1 = write, 0 = read; stable while dreq is high.
REQ-011 SHALL have port daddr, input, 32, data address.
REQ-012 SHALL have port dwdata, input, 32, write data.
REQ-013 SHALL have port drdata, output, 32, read data; valid only while dack is high.
REQ-014 SHALL have port dack, output, 1, one-cycle completion pulse for the data access.
REQ-015 SHALL have port istall, output, 1, combinational ireq & ~iack.
REQ-016 SHALL have port dstall, output, 1, combinational dreq & ~dack.
REQ-017 SHALL have port sram_a, output, 32, SRAM address.
REQ-018 SHALL have port sram_re, output, 1, SRAM read strobe.
REQ-019 SHALL have port sram_we, output, 1, SRAM write strobe.
REQ-020 SHALL have port sram_wdata, output, 32, SRAM write data.
REQ-021 SHALL have port sram_rdata, input, 32, SRAM read data, valid SRAM_LAT cycles after the sram_re cycle.

Function
REQ-022 SHALL implement the states IDLE, ACCESS, WAIT and DONE.
REQ-023 IDLE: with any request present, SHALL pick the winner, latch its address, write data and write flag plus a grant-owner bit, and go to ACCESS; with no request, SHALL stay in IDLE.
REQ-024 Arbitration: dreq SHALL win over ireq unless the starvation counter equals STARVE_MAX, in which case ireq SHALL win.
REQ-025 Starvation counter SHALL increment (saturating at STARVE_MAX) on each data grant made while ireq is high, and SHALL clear on any instruction grant or in any cycle ireq is low.
REQ-026 ACCESS: SHALL last exactly one cycle and drive sram_a from the latched address; a read asserts only sram_re, a write asserts only sram_we and drives sram_wdata.
REQ-027 ACCESS exit: a write SHALL go to DONE, a read SHALL go to WAIT.
REQ-028 WAIT: SHALL last SRAM_LAT cycles; on the final WAIT cycle SHALL register sram_rdata and then go to DONE.
REQ-029 DONE: SHALL last one cycle and pulse the owner's ack; for a read, SHALL present the registered data on the owner's rdata; SHALL then go to IDLE.
REQ-030 Outside their valid windows, sram_re, sram_we, sram_a and sram_wdata SHALL be 0, and sram_re and sram_we SHALL never both be 1.
REQ-031 Outside their ack cycle, irdata and drdata SHALL be 0; iack and dack SHALL never both be 1.
REQ-032 Latency, counting the IDLE cycle in which a request is accepted as cycle 0: write ack SHALL be in cycle 2; read ack SHALL be in cycle 2+SRAM_LAT.
REQ-033 A request still high in the IDLE cycle after its ack SHALL be treated as a new request; requests sampled in ACCESS, WAIT or DONE SHALL be ignored.
REQ-034 Request or address changes by the owner after acceptance SHALL NOT affect the access in flight.
REQ-035 Address bits SHALL pass through unmodified; the block SHALL perform no alignment checks.

Reset
REQ-036 rst high at a clock edge SHALL force IDLE, clear the starvation counter and latched command, and drive all outputs to 0 from the next cycle.
REQ-037 Reset during ACCESS, WAIT or DONE SHALL abort the access with no ack; an aborted write is not guaranteed undone in SRAM.

Verification
REQ-038 Single read, SRAM_LAT=1, ireq with iaddr=0x40 and sram_rdata=0x1234_5678 -> sram_re=1 with sram_a=0x40 in cycle 1 only; iack=1 with irdata=0x1234_5678 in cycle 3.
REQ-039 Simultaneous ireq and a dreq write (daddr=0x100, dwdata=0xAA) -> sram_we in cycle 1 and dack in cycle 2; instruction read accepted in cycle 3 (IDLE).
REQ-040 STARVE_MAX=2, dreq held high continuously with ireq high -> grant order data, data, instruction, with the counter clearing after the instruction grant.
REQ-041 SRAM_LAT=3 read -> three WAIT cycles and ack in cycle 5; a daddr change during WAIT leaves sram_a and the data returned unchanged.
REQ-042 rst asserted during WAIT -> no ack, all outputs 0 the next cycle, IDLE; a following request completes normally.
REQ-043 Every cycle -> sram_re&sram_we==0, iack&dack==0, and istall equals ireq&~iack.
